// File: rtl/pokey_pkg.sv
// Shared types and defaults for the divided-clock tick recovery block.
//   tick_state_t : recovery FSM states
//   DEF_CNT_W    : default period counter width
//   DEF_TIMEOUT  : default loss-of-clock timeout in inClk cycles
package pokey_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED,
      LOST
   } tick_state_t;

   localparam int unsigned DEF_CNT_W   = 16;
   localparam int unsigned DEF_TIMEOUT = 1024;

endpackage

// File: rtl/div_clk_tick_recover_if.sv
// Bundle between a divided-clock source and its tick recovery block.
//   divClk       : divided clock (source -> recovery)
//   tick         : 1-cycle pulse per divClk rising edge
//   fall_tick    : 1-cycle pulse per divClk falling edge
//   period       : last measured rise-to-rise period in inClk cycles
//   period_valid : 1-cycle pulse when period updates
//   locked       : period stable
//   lost         : no rising edge for the timeout window
// master = divClk source side, slave = recovery block side.
interface div_clk_tick_recover_if #(
   parameter int unsigned CNT_W = pokey_pkg::DEF_CNT_W
);

   logic             divClk;
   logic             tick;
   logic             fall_tick;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             lost;

   modport master (
      output divClk,
      input  tick, fall_tick, period, period_valid, locked, lost
   );

   modport slave (
      input  divClk,
      output tick, fall_tick, period, period_valid, locked, lost
   );

endinterface

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into clk and flags its edges.
//   clk, rst_n : clock, async active-low reset
//   divIn      : asynchronous input level
//   rise_c     : synchronized level went 0 -> 1 this cycle (combinational)
//   fall_c     : synchronized level went 1 -> 0 this cycle (combinational)
module sync_edge_det #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic divIn,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] syncQ;
   logic                   prevQ;
   logic                   lvl;

   // Synchronizer chain plus one extra flop holding the previous synchronized level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncQ <= '0;
         prevQ <= 1'b0;
      end else begin
         syncQ <= {syncQ[SYNC_STAGES-2:0], divIn};
         prevQ <= syncQ[SYNC_STAGES-1];
      end
   end

   assign lvl    = syncQ[SYNC_STAGES-1];
   assign rise_c = lvl & ~prevQ;
   assign fall_c = ~lvl & prevQ;

endmodule

// File: rtl/div_clk_tick_recover.sv
// Recovers single-cycle rise/fall tick enables from a divided clock sampled in the
// inClk domain, measures its period, reports lock on a stable period and flags loss.
//   inClk, rst_n : sole clock, async active-low reset
//   bus (slave)  : divClk in; tick, fall_tick, period, period_valid, locked, lost out
module div_clk_tick_recover
   import pokey_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned LOCK_COUNT  = 4,
   parameter int unsigned TOL         = 1,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
   input logic                   inClk,
   input logic                   rst_n,
   div_clk_tick_recover_if.slave bus
);

   localparam int unsigned DIFF_W  = CNT_W + 1;
   localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_TO     = CNT_W'(TIMEOUT - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [DIFF_W-1:0]  TOL_D      = DIFF_W'(TOL);

   tick_state_t        state, stateNext;
   logic               rise, fall;
   logic [CNT_W-1:0]   cnt, cntNext, measP;
   logic [CNT_W-1:0]   refP, refNext;
   logic               haveRef, haveRefNext;
   logic [MATCH_W-1:0] matchCnt, matchNext;
   logic [CNT_W-1:0]   periodQ, periodNext;
   logic               pvNext;
   logic [DIFF_W-1:0]  measD, refD, diff;
   logic               isMatch, timeoutHit;
   logic               tickQ, fallQ, pvQ, lockedQ, lostQ;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (inClk),
      .rst_n (rst_n),
      .divIn (bus.divClk),
      .rise_c(rise),
      .fall_c(fall)
   );

   // Saturating period measurement and tolerance compare against the reference.
   always_comb begin
      measP      = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      cntNext    = rise ? '0 : measP;
      measD      = {1'b0, measP};
      refD       = {1'b0, refP};
      diff       = (measD >= refD) ? (measD - refD) : (refD - measD);
      isMatch    = (diff <= TOL_D);
      timeoutHit = (cnt == CNT_TO);
   end

   // FSM state register.
   always_ff @(posedge inClk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // Next-state, reference/match bookkeeping and period update.
   always_comb begin
      stateNext   = state;
      refNext     = refP;
      haveRefNext = haveRef;
      matchNext   = matchCnt;
      periodNext  = periodQ;
      pvNext      = 1'b0;
      case (state)
         IDLE: begin
            // First edge after reset has no prior edge to measure from.
            if (rise) begin
               stateNext   = MEASURE;
               haveRefNext = 1'b0;
               matchNext   = '0;
            end
         end
         MEASURE: begin
            if (rise) begin
               periodNext  = measP;
               pvNext      = 1'b1;
               refNext     = measP;
               haveRefNext = 1'b1;
               if (!haveRef) begin
                  matchNext = '0;
               end else if (isMatch) begin
                  matchNext = matchCnt + MATCH_W'(1);
                  if (matchCnt == MATCH_LAST) stateNext = LOCKED;
               end else begin
                  matchNext = '0;
               end
            end else if (timeoutHit) begin
               stateNext   = LOST;
               haveRefNext = 1'b0;
               matchNext   = '0;
            end
         end
         LOCKED: begin
            if (rise) begin
               periodNext = measP;
               pvNext     = 1'b1;
               refNext    = measP;
               if (!isMatch) begin
                  stateNext = MEASURE;
                  matchNext = '0;
               end
            end else if (timeoutHit) begin
               stateNext   = LOST;
               haveRefNext = 1'b0;
               matchNext   = '0;
            end
         end
         LOST: begin
            // Resumed clock: the interval spanning the outage is not a valid period.
            if (rise) begin
               stateNext   = MEASURE;
               haveRefNext = 1'b0;
               matchNext   = '0;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge inClk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         refP     <= '0;
         haveRef  <= 1'b0;
         matchCnt <= '0;
         periodQ  <= '0;
         pvQ      <= 1'b0;
         tickQ    <= 1'b0;
         fallQ    <= 1'b0;
         lockedQ  <= 1'b0;
         lostQ    <= 1'b0;
      end else begin
         cnt      <= cntNext;
         refP     <= refNext;
         haveRef  <= haveRefNext;
         matchCnt <= matchNext;
         periodQ  <= periodNext;
         pvQ      <= pvNext;
         tickQ    <= rise;
         fallQ    <= fall;
         lockedQ  <= (stateNext == LOCKED);
         lostQ    <= (stateNext == LOST);
      end
   end

   assign bus.tick         = tickQ;
   assign bus.fall_tick    = fallQ;
   assign bus.period       = periodQ;
   assign bus.period_valid = pvQ;
   assign bus.locked       = lockedQ;
   assign bus.lost         = lostQ;

endmodule
